id_ex_stage: RTL and testbench

Decode-to-execute pipeline stage for the 5-stage MIPS core. It contains three parts. The ID/EX pipeline register captures the decode-stage control and data. A read-use decoder reports which source registers the instruction in decode reads. A destination decoder reports which register, if any, the instruction held in EXE will write. The stall controller compares the read-use flags against the destination reports of later stages to detect RAW hazards; stall bubbles enter this stage through `flush`.

---
 rtl/id_ex_stage.sv | 81 ++++++++
 tb/tb_id_ex_stage.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with read-use and destination decoders for hazard detection
module id_ex_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        flush,
  input  logic [31:0] instruction_ID,
  input  logic        RegWrite_ID,
  input  logic        DataC_ID,
  input  logic        MemtoReg_ID,
  input  logic        MemWrite_ID,
  input  logic        MemRead_ID,
  input  logic        AluSrc_ID,
  input  logic        AluSrc1_ID,
  input  logic        Branch_ID,
  input  logic        NBranch_ID,
  input  logic [3:0]  AluOperation_ID,
  input  logic [31:0] read_data1_ID,
  input  logic [31:0] read_data2_ID,
  input  logic [31:0] inst_extended_ID,
  input  logic [31:0] pc_adder_ID,
  input  logic [4:0]  write_reg_ID,
  input  logic [4:0]  Shamnt_ID,
  output logic [31:0] instruction_EXE,
  output logic        RegWrite_EXE,
  output logic        DataC_EXE,
  output logic        MemtoReg_EXE,
  output logic        MemWrite_EXE,
  output logic        MemRead_EXE,
  output logic        AluSrc_EXE,
  output logic        AluSrc1_EXE,
  output logic        Branch_EXE,
  output logic        NBranch_EXE,
  output logic [3:0]  AluOperation_EXE,
  output logic [31:0] read_data1_EXE,
  output logic [31:0] read_data2_EXE,
  output logic [31:0] inst_extended_EXE,
  output logic [31:0] pc_adder_EXE,
  output logic [4:0]  write_reg_EXE,
  output logic [4:0]  Shamnt_EXE,
  output logic        re1_ID,
  output logic        re2_ID,
  output logic [4:0]  ws_EXE,
  output logic        we_EXE
);
  localparam int W = 183;
  logic [W-1:0] d, q;
  assign d = {instruction_ID, RegWrite_ID, DataC_ID, MemtoReg_ID, MemWrite_ID, MemRead_ID,
              AluSrc_ID, AluSrc1_ID, Branch_ID, NBranch_ID, AluOperation_ID, read_data1_ID,
              read_data2_ID, inst_extended_ID, pc_adder_ID, write_reg_ID, Shamnt_ID};
  assign {instruction_EXE, RegWrite_EXE, DataC_EXE, MemtoReg_EXE, MemWrite_EXE, MemRead_EXE,
          AluSrc_EXE, AluSrc1_EXE, Branch_EXE, NBranch_EXE, AluOperation_EXE, read_data1_EXE,
          read_data2_EXE, inst_extended_EXE, pc_adder_EXE, write_reg_EXE, Shamnt_EXE} = q;
  always_ff @(posedge clk or negedge rst)
    if (!rst) q <= '0;
    else if (flush) q <= '0;
    else if (enable) q <= d;
  function automatic logic is_ralu(input logic [31:0] i);
    return i[31:26] == 6'h00 && i[5:0] inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
  endfunction
  function automatic logic is_shift(input logic [31:0] i);
    return i[31:26] == 6'h00 && i[5:0] inside {6'h00, 6'h02};
  endfunction
  function automatic logic is_jr(input logic [31:0] i);
    return i[31:26] == 6'h00 && i[5:0] == 6'h08;
  endfunction
  function automatic logic is_imm(input logic [31:0] i);
    return i[31:26] inside {6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h23};
  endfunction
  function automatic logic is_rsrt(input logic [31:0] i);
    return i[31:26] inside {6'h2B, 6'h04, 6'h05};
  endfunction
  assign re1_ID = (is_ralu(instruction_ID) || is_jr(instruction_ID) || is_imm(instruction_ID) ||
                   is_rsrt(instruction_ID)) && |instruction_ID[25:21];
  assign re2_ID = (is_ralu(instruction_ID) || is_shift(instruction_ID) || is_rsrt(instruction_ID)) &&
                  |instruction_ID[20:16];
  assign ws_EXE = is_ralu(instruction_EXE) || is_shift(instruction_EXE) ? instruction_EXE[15:11] :
                  is_imm(instruction_EXE) ? instruction_EXE[20:16] :
                  instruction_EXE[31:26] == 6'h03 ? 5'd31 : 5'd0;
  assign we_EXE = |ws_EXE;
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: randomized self-checking bench for id_ex_stage against a decode-table model
module tb_id_ex_stage;
  logic        clk = 0, rst = 0, enable = 0, flush = 0;
  logic [31:0] instruction_ID = 0, read_data1_ID = 0, read_data2_ID = 0, inst_extended_ID = 0, pc_adder_ID = 0;
  logic [8:0]  ctl_ID = 0;
  logic [3:0]  AluOperation_ID = 0;
  logic [4:0]  write_reg_ID = 0, Shamnt_ID = 0;
  logic [31:0] instruction_EXE, read_data1_EXE, read_data2_EXE, inst_extended_EXE, pc_adder_EXE;
  logic [8:0]  ctl_EXE;
  logic [3:0]  AluOperation_EXE;
  logic [4:0]  write_reg_EXE, Shamnt_EXE, ws_EXE;
  logic        re1_ID, re2_ID, we_EXE;
  int checks = 0, errors = 0;
  logic [31:0] m_instr, m_rd1, m_rd2, m_ext, m_pc;
  logic [8:0]  m_ctl;
  logic [3:0]  m_op;
  logic [4:0]  m_wr, m_sh;

  id_ex_stage dut (
    .clk(clk), .rst(rst), .enable(enable), .flush(flush),
    .instruction_ID(instruction_ID),
    .RegWrite_ID(ctl_ID[8]), .DataC_ID(ctl_ID[7]), .MemtoReg_ID(ctl_ID[6]), .MemWrite_ID(ctl_ID[5]),
    .MemRead_ID(ctl_ID[4]), .AluSrc_ID(ctl_ID[3]), .AluSrc1_ID(ctl_ID[2]), .Branch_ID(ctl_ID[1]),
    .NBranch_ID(ctl_ID[0]), .AluOperation_ID(AluOperation_ID),
    .read_data1_ID(read_data1_ID), .read_data2_ID(read_data2_ID),
    .inst_extended_ID(inst_extended_ID), .pc_adder_ID(pc_adder_ID),
    .write_reg_ID(write_reg_ID), .Shamnt_ID(Shamnt_ID),
    .instruction_EXE(instruction_EXE),
    .RegWrite_EXE(ctl_EXE[8]), .DataC_EXE(ctl_EXE[7]), .MemtoReg_EXE(ctl_EXE[6]), .MemWrite_EXE(ctl_EXE[5]),
    .MemRead_EXE(ctl_EXE[4]), .AluSrc_EXE(ctl_EXE[3]), .AluSrc1_EXE(ctl_EXE[2]), .Branch_EXE(ctl_EXE[1]),
    .NBranch_EXE(ctl_EXE[0]), .AluOperation_EXE(AluOperation_EXE),
    .read_data1_EXE(read_data1_EXE), .read_data2_EXE(read_data2_EXE),
    .inst_extended_EXE(inst_extended_EXE), .pc_adder_EXE(pc_adder_EXE),
    .write_reg_EXE(write_reg_EXE), .Shamnt_EXE(Shamnt_EXE),
    .re1_ID(re1_ID), .re2_ID(re2_ID), .ws_EXE(ws_EXE), .we_EXE(we_EXE)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void ref_reads(input logic [31:0] i, output logic r1, output logic r2);
    r1 = 0;
    r2 = 0;
    case (i[31:26])
      6'h00:
        case (i[5:0])
          6'h20, 6'h22, 6'h24, 6'h25, 6'h2A: begin r1 = 1; r2 = 1; end
          6'h00, 6'h02: r2 = 1;
          6'h08: r1 = 1;
          default: ;
        endcase
      6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h23: r1 = 1;
      6'h2B, 6'h04, 6'h05: begin r1 = 1; r2 = 1; end
      default: ;
    endcase
    if (i[25:21] == 0) r1 = 0;
    if (i[20:16] == 0) r2 = 0;
  endfunction

  function automatic void ref_dest(input logic [31:0] i, output logic [4:0] ws, output logic we);
    logic w = 0;
    ws = 0;
    case (i[31:26])
      6'h00:
        if (i[5:0] inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h00, 6'h02}) begin ws = i[15:11]; w = 1; end
      6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h23: begin ws = i[20:16]; w = 1; end
      6'h03: begin ws = 5'd31; w = 1; end
      default: ;
    endcase
    we = w && ws != 0;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [5:0] op, fn;
    logic [4:0] rs, rt, rd;
    if ($urandom_range(0, 9) == 0) return $urandom;
    rs = $urandom_range(0, 3) == 0 ? 5'd0 : 5'($urandom);
    rt = $urandom_range(0, 3) == 0 ? 5'd0 : 5'($urandom);
    rd = $urandom_range(0, 3) == 0 ? 5'd0 : 5'($urandom);
    case ($urandom_range(0, 13))
      0, 1, 2: op = 6'h00;
      3: op = 6'h08;
      4: op = 6'h0A;
      5: op = 6'h0C;
      6: op = 6'h0D;
      7: op = 6'h23;
      8: op = 6'h2B;
      9: op = 6'h04;
      10: op = 6'h05;
      11: op = 6'h02;
      12: op = 6'h03;
      default: op = 6'($urandom);
    endcase
    case ($urandom_range(0, 8))
      0: fn = 6'h20;
      1: fn = 6'h22;
      2: fn = 6'h24;
      3: fn = 6'h25;
      4: fn = 6'h2A;
      5: fn = 6'h00;
      6: fn = 6'h02;
      7: fn = 6'h08;
      default: fn = 6'($urandom);
    endcase
    return {op, rs, rt, rd, 5'($urandom), fn};
  endfunction

  task automatic drive_all(input logic [31:0] v);
    instruction_ID = v; read_data1_ID = v; read_data2_ID = v; inst_extended_ID = v; pc_adder_ID = v;
    ctl_ID = v[8:0]; AluOperation_ID = v[3:0]; write_reg_ID = v[4:0]; Shamnt_ID = v[4:0];
  endtask

  task automatic drive_rand();
    instruction_ID = rand_instr();
    read_data1_ID = $urandom; read_data2_ID = $urandom; inst_extended_ID = $urandom; pc_adder_ID = $urandom;
    ctl_ID = 9'($urandom); AluOperation_ID = 4'($urandom); write_reg_ID = 5'($urandom); Shamnt_ID = 5'($urandom);
  endtask

  task automatic model_clear();
    m_instr = 0; m_rd1 = 0; m_rd2 = 0; m_ext = 0; m_pc = 0; m_ctl = 0; m_op = 0; m_wr = 0; m_sh = 0;
  endtask

  task automatic check_all(input string tag);
    logic [4:0] ws;
    logic we;
    ref_dest(m_instr, ws, we);
    chk({tag, ".instr"}, instruction_EXE, m_instr);
    chk({tag, ".ctl"}, 32'(ctl_EXE), 32'(m_ctl));
    chk({tag, ".aluop"}, 32'(AluOperation_EXE), 32'(m_op));
    chk({tag, ".rd1"}, read_data1_EXE, m_rd1);
    chk({tag, ".rd2"}, read_data2_EXE, m_rd2);
    chk({tag, ".ext"}, inst_extended_EXE, m_ext);
    chk({tag, ".pc"}, pc_adder_EXE, m_pc);
    chk({tag, ".wr"}, 32'(write_reg_EXE), 32'(m_wr));
    chk({tag, ".sh"}, 32'(Shamnt_EXE), 32'(m_sh));
    chk({tag, ".ws"}, 32'(ws_EXE), 32'(ws));
    chk({tag, ".we"}, 32'(we_EXE), 32'(we));
  endtask

  task automatic check_reads(input string tag);
    logic r1, r2;
    #1;
    ref_reads(instruction_ID, r1, r2);
    chk({tag, ".re1"}, 32'(re1_ID), 32'(r1));
    chk({tag, ".re2"}, 32'(re2_ID), 32'(r2));
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    if (flush) model_clear();
    else if (enable) begin
      m_instr = instruction_ID; m_rd1 = read_data1_ID; m_rd2 = read_data2_ID; m_ext = inst_extended_ID;
      m_pc = pc_adder_ID; m_ctl = ctl_ID; m_op = AluOperation_ID; m_wr = write_reg_ID; m_sh = Shamnt_ID;
    end
    #1 check_all(tag);
  endtask

  task automatic read_case(input string tag, input logic [31:0] i, input logic e1, input logic e2);
    instruction_ID = i;
    #1;
    chk({tag, ".re1"}, 32'(re1_ID), 32'(e1));
    chk({tag, ".re2"}, 32'(re2_ID), 32'(e2));
  endtask

  task automatic dest_case(input string tag, input logic [31:0] i, input logic [4:0] ews, input logic ewe);
    @(negedge clk);
    instruction_ID = i; enable = 1; flush = 0;
    step(tag);
    chk({tag, ".ws_k"}, 32'(ws_EXE), 32'(ews));
    chk({tag, ".we_k"}, 32'(we_EXE), 32'(ewe));
  endtask

  initial begin
    model_clear();
    repeat (2) @(posedge clk);
    #1 check_all("reset_init");
    @(negedge clk);
    rst = 1; enable = 1;
    drive_all('1);
    step("load_ones");
    @(negedge clk);
    #2 rst = 0;
    #1 model_clear();
    check_all("async_reset");
    @(negedge clk);
    chk("reset_hold.instr", instruction_EXE, 32'h0);
    rst = 1;
    drive_all('0);
    instruction_ID = 32'h012A4020; enable = 1;
    step("add_load");
    chk("add.instr_k", instruction_EXE, 32'h012A4020);
    chk("add.ws_k", 32'(ws_EXE), 32'd8);
    chk("add.we_k", 32'(we_EXE), 32'd1);
    @(negedge clk);
    enable = 0;
    drive_all(32'h5A5A_1234);
    step("hold");
    chk("hold.instr_k", instruction_EXE, 32'h012A4020);
    @(negedge clk);
    flush = 1; enable = 0;
    drive_all(32'hDEAD_BEEF);
    step("flush");
    chk("flush.we_k", 32'(we_EXE), 32'd0);
    @(negedge clk);
    flush = 1; enable = 1;
    step("flush_over_enable");
    chk("flush_en.instr_k", instruction_EXE, 32'h0);
    @(negedge clk);
    flush = 0;
    read_case("lw", 32'h8D090004, 1, 0);
    read_case("sw", 32'hAD090004, 1, 1);
    read_case("j", 32'h08000010, 0, 0);
    read_case("add_rs0", 32'h000A4020, 0, 1);
    read_case("bubble", 32'h0, 0, 0);
    dest_case("jal", 32'h0C000010, 5'd31, 1);
    dest_case("beq", 32'h11090003, 5'd0, 0);
    dest_case("addi_r0", 32'h20200005, 5'd0, 0);
    @(negedge clk);
    drive_rand();
    AluOperation_ID = 4'hA; ctl_ID = 9'b0_0000_0010; pc_adder_ID = 32'h40; Shamnt_ID = 5'd7; enable = 1;
    step("pass");
    chk("pass.aluop_k", 32'(AluOperation_EXE), 32'hA);
    chk("pass.branch_k", 32'(ctl_EXE[1]), 32'd1);
    chk("pass.pc_k", pc_adder_EXE, 32'h40);
    chk("pass.sh_k", 32'(Shamnt_EXE), 32'd7);
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      if ($urandom_range(0, 39) == 0) begin
        #1 rst = 0;
        #1 model_clear();
        check_all("rand_reset");
        #1 rst = 1;
      end
      drive_rand();
      enable = $urandom_range(0, 9) < 7;
      flush = $urandom_range(0, 9) == 0;
      check_reads("rand");
      step("rand");
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
